// File: rtl/armleocpu_axi_lite_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : armleocpu_axi_lite_arbiter
// Brief   : Round-robin sharing of one AXI4-Lite device port between
//           HOST_COUNT hosts, one transaction in flight at a time.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module armleocpu_axi_lite_arbiter #(
    parameter int HOST_COUNT = 2,
    parameter int ADDR_WIDTH = 34
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [HOST_COUNT-1:0]            host_axi_awvalid,
    output logic [HOST_COUNT-1:0]            host_axi_awready,
    input  logic [HOST_COUNT*ADDR_WIDTH-1:0] host_axi_awaddr,
    input  logic [HOST_COUNT-1:0]            host_axi_wvalid,
    output logic [HOST_COUNT-1:0]            host_axi_wready,
    input  logic [HOST_COUNT*32-1:0]         host_axi_wdata,
    input  logic [HOST_COUNT*4-1:0]          host_axi_wstrb,
    output logic [HOST_COUNT-1:0]            host_axi_bvalid,
    input  logic [HOST_COUNT-1:0]            host_axi_bready,
    output logic [HOST_COUNT*2-1:0]          host_axi_bresp,
    input  logic [HOST_COUNT-1:0]            host_axi_arvalid,
    output logic [HOST_COUNT-1:0]            host_axi_arready,
    input  logic [HOST_COUNT*ADDR_WIDTH-1:0] host_axi_araddr,
    output logic [HOST_COUNT-1:0]            host_axi_rvalid,
    input  logic [HOST_COUNT-1:0]            host_axi_rready,
    output logic [HOST_COUNT*2-1:0]          host_axi_rresp,
    output logic [HOST_COUNT*32-1:0]         host_axi_rdata,

    output logic                             axi_awvalid,
    input  logic                             axi_awready,
    output logic [ADDR_WIDTH-1:0]            axi_awaddr,
    output logic                             axi_wvalid,
    input  logic                             axi_wready,
    output logic [31:0]                      axi_wdata,
    output logic [3:0]                       axi_wstrb,
    input  logic                             axi_bvalid,
    output logic                             axi_bready,
    input  logic [1:0]                       axi_bresp,
    output logic                             axi_arvalid,
    input  logic                             axi_arready,
    output logic [ADDR_WIDTH-1:0]            axi_araddr,
    input  logic                             axi_rvalid,
    output logic                             axi_rready,
    input  logic [1:0]                       axi_rresp,
    input  logic [31:0]                      axi_rdata
);

    localparam int DATA_WIDTH   = 32;
    localparam int DATA_STROBES = 4;
    localparam int c_GW         = (HOST_COUNT > 1) ? $clog2(HOST_COUNT) : 1;
    localparam logic [c_GW-1:0] c_LAST_HOST = c_GW'(HOST_COUNT - 1);

    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_WRITE_ADDR = 3'd1;
    localparam logic [2:0] c_S_WRITE_RESP = 3'd2;
    localparam logic [2:0] c_S_READ_ADDR  = 3'd3;
    localparam logic [2:0] c_S_READ_RESP  = 3'd4;

    logic [2:0]            r_state, w_state_nxt;
    logic [c_GW-1:0]       r_grant, w_grant_nxt;
    logic [c_GW-1:0]       r_last_grant, w_last_grant_nxt;
    logic                  r_aw_done, w_aw_done_nxt;
    logic                  r_w_done, w_w_done_nxt;

    logic [HOST_COUNT-1:0] w_wreq, w_rreq;
    logic                  w_win_found, w_win_write;
    logic [c_GW-1:0]       w_win_idx;
    logic                  w_aw_hs, w_w_hs;

    assign w_wreq = host_axi_awvalid & host_axi_wvalid;
    assign w_rreq = host_axi_arvalid;

    // Scan starts just after the last served host so every requester gets a turn.
    always_comb begin : p_arb
        int v_idx;
        w_win_found = 1'b0;
        w_win_write = 1'b0;
        w_win_idx   = '0;
        v_idx       = 0;
        for (int k = 1; k <= HOST_COUNT; k++) begin
            v_idx = (int'(r_last_grant) + k) % HOST_COUNT;
            if (!w_win_found && (w_wreq[v_idx[c_GW-1:0]] || w_rreq[v_idx[c_GW-1:0]])) begin
                w_win_found = 1'b1;
                w_win_idx   = v_idx[c_GW-1:0];
                w_win_write = w_wreq[v_idx[c_GW-1:0]];
            end
        end
    end

    assign axi_awaddr = host_axi_awaddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign axi_araddr = host_axi_araddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign axi_wdata  = host_axi_wdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign axi_wstrb  = host_axi_wstrb[r_grant*DATA_STROBES +: DATA_STROBES];

    generate
        for (genvar i = 0; i < HOST_COUNT; i++) begin : g_host
            assign host_axi_bresp[i*2 +: 2]                  = axi_bresp;
            assign host_axi_rresp[i*2 +: 2]                  = axi_rresp;
            assign host_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH] = axi_rdata;
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_aw_done_nxt    = r_aw_done;
        w_w_done_nxt     = r_w_done;
        w_aw_hs          = 1'b0;
        w_w_hs           = 1'b0;
        host_axi_awready = '0;
        host_axi_wready  = '0;
        host_axi_bvalid  = '0;
        host_axi_arready = '0;
        host_axi_rvalid  = '0;
        axi_awvalid      = 1'b0;
        axi_wvalid       = 1'b0;
        axi_bready       = 1'b0;
        axi_arvalid      = 1'b0;
        axi_rready       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_win_found) begin
                    w_grant_nxt = w_win_idx;
                    w_state_nxt = w_win_write ? c_S_WRITE_ADDR : c_S_READ_ADDR;
                end
            end
            c_S_WRITE_ADDR: begin
                // Done flags mask each half so a channel is never handshaken twice.
                axi_awvalid               = host_axi_awvalid[r_grant] && !r_aw_done;
                axi_wvalid                = host_axi_wvalid[r_grant] && !r_w_done;
                host_axi_awready[r_grant] = axi_awready && !r_aw_done;
                host_axi_wready[r_grant]  = axi_wready && !r_w_done;
                w_aw_hs                   = axi_awvalid && axi_awready;
                w_w_hs                    = axi_wvalid && axi_wready;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt   = c_S_WRITE_RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = r_aw_done || w_aw_hs;
                    w_w_done_nxt  = r_w_done || w_w_hs;
                end
            end
            c_S_WRITE_RESP: begin
                axi_bready               = host_axi_bready[r_grant];
                host_axi_bvalid[r_grant] = axi_bvalid;
                if (axi_bvalid && axi_bready) begin
                    w_state_nxt      = c_S_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            c_S_READ_ADDR: begin
                axi_arvalid               = host_axi_arvalid[r_grant];
                host_axi_arready[r_grant] = axi_arready;
                if (axi_arvalid && axi_arready)
                    w_state_nxt = c_S_READ_RESP;
            end
            c_S_READ_RESP: begin
                axi_rready               = host_axi_rready[r_grant];
                host_axi_rvalid[r_grant] = axi_rvalid;
                if (axi_rvalid && axi_rready) begin
                    w_state_nxt      = c_S_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_HOST;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_axi_lite_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_armleocpu_axi_lite_arbiter
// Brief   : Directed self-checking bench for the two-host AXI4-Lite arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_armleocpu_axi_lite_arbiter;

    localparam int N  = 2;
    localparam int AW = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    host_axi_awvalid, host_axi_awready;
    logic [N*AW-1:0] host_axi_awaddr;
    logic [N-1:0]    host_axi_wvalid, host_axi_wready;
    logic [N*32-1:0] host_axi_wdata;
    logic [N*4-1:0]  host_axi_wstrb;
    logic [N-1:0]    host_axi_bvalid, host_axi_bready;
    logic [N*2-1:0]  host_axi_bresp;
    logic [N-1:0]    host_axi_arvalid, host_axi_arready;
    logic [N*AW-1:0] host_axi_araddr;
    logic [N-1:0]    host_axi_rvalid, host_axi_rready;
    logic [N*2-1:0]  host_axi_rresp;
    logic [N*32-1:0] host_axi_rdata;

    logic            axi_awvalid, axi_awready;
    logic [AW-1:0]   axi_awaddr;
    logic            axi_wvalid, axi_wready;
    logic [31:0]     axi_wdata;
    logic [3:0]      axi_wstrb;
    logic            axi_bvalid, axi_bready;
    logic [1:0]      axi_bresp;
    logic            axi_arvalid, axi_arready;
    logic [AW-1:0]   axi_araddr;
    logic            axi_rvalid, axi_rready;
    logic [1:0]      axi_rresp;
    logic [31:0]     axi_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    armleocpu_axi_lite_arbiter #(.HOST_COUNT(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_axi_awvalid(host_axi_awvalid), .host_axi_awready(host_axi_awready), .host_axi_awaddr(host_axi_awaddr),
        .host_axi_wvalid(host_axi_wvalid), .host_axi_wready(host_axi_wready),
        .host_axi_wdata(host_axi_wdata), .host_axi_wstrb(host_axi_wstrb),
        .host_axi_bvalid(host_axi_bvalid), .host_axi_bready(host_axi_bready), .host_axi_bresp(host_axi_bresp),
        .host_axi_arvalid(host_axi_arvalid), .host_axi_arready(host_axi_arready), .host_axi_araddr(host_axi_araddr),
        .host_axi_rvalid(host_axi_rvalid), .host_axi_rready(host_axi_rready),
        .host_axi_rresp(host_axi_rresp), .host_axi_rdata(host_axi_rdata),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp), .axi_rdata(axi_rdata)
    );

    always #5 clk = ~clk;

    // Every handshake-control output of the arbiter, for "all quiet" checks.
    function automatic logic [14:0] all_vr();
        return {host_axi_awready, host_axi_wready, host_axi_bvalid, host_axi_arready, host_axi_rvalid,
                axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready};
    endfunction

    task automatic clear_inputs();
        host_axi_awvalid = '0; host_axi_awaddr = '0; host_axi_wvalid = '0; host_axi_wdata = '0;
        host_axi_wstrb = '0; host_axi_bready = '0; host_axi_arvalid = '0; host_axi_araddr = '0;
        host_axi_rready = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rresp = 2'b00; axi_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL reset_quiet: got %h want 0", all_vr()); end
        @(negedge clk);
        rst_n = 1'b1;
        host_axi_arvalid = 2'b01; host_axi_araddr[0 +: AW] = 34'h8; axi_arready = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (host_axi_arready !== 2'b01 || axi_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_grant: arready=%b arvalid=%b want 01/1", host_axi_arready, axi_arvalid);
        end
        @(negedge clk);
        host_axi_arvalid = 2'b00; axi_rvalid = 1'b1; axi_rdata = 32'hCAFE0001; host_axi_rready = 2'b00;
        #1;
        n_cmp++;
        if (host_axi_rvalid !== 2'b01) begin n_fail++; $display("FAIL reset_rresp_pending: rvalid=%b want 01", host_axi_rvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL reset_mid_rresp: got %h want 0", all_vr()); end
        @(negedge clk);
        rst_n = 1'b1; axi_rvalid = 1'b0;
        host_axi_arvalid = 2'b10; host_axi_araddr[AW +: AW] = 34'hC;
        @(negedge clk); #1;
        n_cmp++;
        if (host_axi_arready !== 2'b10 || axi_araddr !== 34'hC) begin
            n_fail++; $display("FAIL reset_regrant: arready=%b araddr=%h want 10/00c", host_axi_arready, axi_araddr);
        end
        @(negedge clk);
        host_axi_arvalid = 2'b00; axi_rvalid = 1'b1; axi_rdata = 32'h55; host_axi_rready = 2'b10;
        #1;
        n_cmp++;
        if (host_axi_rvalid !== 2'b10 || axi_rready !== 1'b1) begin
            n_fail++; $display("FAIL reset_h1_rresp: rvalid=%b rready=%b want 10/1", host_axi_rvalid, axi_rready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL reset_back_idle: got %h want 0", all_vr()); end
    endtask

    task automatic test_write();
        host_axi_awvalid = 2'b01; host_axi_wvalid = 2'b01;
        host_axi_awaddr[0 +: AW] = 34'h10; host_axi_wdata[0 +: 32] = 32'hDEADBEEF; host_axi_wstrb[0 +: 4] = 4'hF;
        axi_awready = 1'b1; axi_wready = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1 || axi_awaddr !== 34'h10) begin
            n_fail++; $display("FAIL write_addr: awv=%b wv=%b awaddr=%h want 1/1/010", axi_awvalid, axi_wvalid, axi_awaddr);
        end
        n_cmp++;
        if (axi_wdata !== 32'hDEADBEEF || axi_wstrb !== 4'hF) begin
            n_fail++; $display("FAIL write_data: wdata=%h wstrb=%h want deadbeef/f", axi_wdata, axi_wstrb);
        end
        n_cmp++;
        if (host_axi_awready !== 2'b01 || host_axi_wready !== 2'b01) begin
            n_fail++; $display("FAIL write_ready_route: awready=%b wready=%b want 01/01", host_axi_awready, host_axi_wready);
        end
        @(negedge clk);
        host_axi_awvalid = 2'b00; host_axi_wvalid = 2'b00;
        axi_bvalid = 1'b1; axi_bresp = 2'b00; host_axi_bready = 2'b01;
        #1;
        n_cmp++;
        if (host_axi_bvalid !== 2'b01 || host_axi_bresp[1:0] !== 2'b00 || axi_bready !== 1'b1) begin
            n_fail++; $display("FAIL write_resp: bvalid=%b bresp=%b bready=%b want 01/00/1",
                               host_axi_bvalid, host_axi_bresp[1:0], axi_bready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL write_idle: got %h want 0", all_vr()); end
    endtask

    task automatic test_read_stall();
        host_axi_arvalid = 2'b10; host_axi_araddr[AW +: AW] = 34'h4; axi_arready = 1'b1; host_axi_rready = 2'b10;
        @(negedge clk); #1;
        n_cmp++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 34'h4 || host_axi_arready !== 2'b10) begin
            n_fail++; $display("FAIL read_addr: arv=%b araddr=%h arready=%b want 1/004/10", axi_arvalid, axi_araddr, host_axi_arready);
        end
        @(negedge clk);
        host_axi_arvalid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (host_axi_rvalid !== 2'b00 || axi_rready !== 1'b1) begin
                n_fail++; $display("FAIL read_stall_%0d: rvalid=%b rready=%b want 00/1", c, host_axi_rvalid, axi_rready);
            end
            @(negedge clk);
        end
        axi_rvalid = 1'b1; axi_rdata = 32'h12345678; axi_rresp = 2'b00;
        #1;
        n_cmp++;
        if (host_axi_rvalid !== 2'b10 || host_axi_rdata[63:32] !== 32'h12345678 || host_axi_rresp[3:2] !== 2'b00) begin
            n_fail++; $display("FAIL read_data: rvalid=%b rdata=%h rresp=%b want 10/12345678/00",
                               host_axi_rvalid, host_axi_rdata[63:32], host_axi_rresp[3:2]);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL read_idle: got %h want 0", all_vr()); end
    endtask

    task automatic test_round_robin();
        int grants[6];
        int n = 0;
        host_axi_arvalid = 2'b11; host_axi_rready = 2'b11; axi_arready = 1'b1; axi_rvalid = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk); #1;
            if (axi_arvalid) begin
                grants[n] = host_axi_arready[1] ? 1 : 0;
                n++;
            end
        end
        n_cmp++;
        if (n !== 6) begin n_fail++; $display("FAIL rr_count: got %0d grants want 6", n); end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (grants[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_order_%0d: got host %0d want %0d", i, grants[i], i % 2); end
        end
        @(negedge clk);
        host_axi_arvalid = 2'b00;
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL rr_idle: got %h want 0", all_vr()); end
    endtask

    task automatic test_write_priority();
        int ev[3];
        int n = 0;
        logic       drop_w = 1'b0;
        logic [1:0] drop_ar = 2'b00;
        host_axi_awvalid = 2'b01; host_axi_wvalid = 2'b01; host_axi_arvalid = 2'b11;
        host_axi_awaddr[0 +: AW] = 34'h30; host_axi_araddr[0 +: AW] = 34'h34; host_axi_araddr[AW +: AW] = 34'h38;
        host_axi_bready = 2'b11; host_axi_rready = 2'b11;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1; axi_bvalid = 1'b1; axi_rvalid = 1'b1;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (drop_w) begin host_axi_awvalid = 2'b00; host_axi_wvalid = 2'b00; end
            host_axi_arvalid = host_axi_arvalid & ~drop_ar;
            #1;
            if (axi_awvalid && axi_awready) begin
                ev[n] = 10 + (host_axi_awready[1] ? 1 : 0); n++; drop_w = 1'b1;
            end else if (axi_arvalid) begin
                ev[n] = host_axi_arready[1] ? 1 : 0; n++; drop_ar = drop_ar | host_axi_arready;
            end
        end
        n_cmp++;
        if (n !== 3) begin n_fail++; $display("FAIL prio_count: got %0d events want 3", n); end
        n_cmp++;
        if (n > 0 && ev[0] !== 10) begin n_fail++; $display("FAIL prio_first: got %0d want 10 (write host0)", ev[0]); end
        n_cmp++;
        if (n > 1 && ev[1] !== 1) begin n_fail++; $display("FAIL prio_second: got %0d want 1 (read host1)", ev[1]); end
        n_cmp++;
        if (n > 2 && ev[2] !== 0) begin n_fail++; $display("FAIL prio_third: got %0d want 0 (read host0)", ev[2]); end
        @(negedge clk);
        host_axi_arvalid = 2'b00;
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL prio_idle: got %h want 0", all_vr()); end
    endtask

    task automatic test_w_before_aw();
        int aw_hs = 0;
        int w_hs  = 0;
        host_axi_awvalid = 2'b10; host_axi_wvalid = 2'b10;
        host_axi_awaddr[AW +: AW] = 34'h20; host_axi_wdata[32 +: 32] = 32'hA5A55A5A; host_axi_wstrb[4 +: 4] = 4'h3;
        axi_awready = 1'b0; axi_wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) axi_awready = 1'b1;
            #1;
            if (c == 0) begin
                n_cmp++;
                if (axi_awaddr !== 34'h20 || axi_wdata !== 32'hA5A55A5A || axi_wstrb !== 4'h3) begin
                    n_fail++; $display("FAIL wfirst_payload: awaddr=%h wdata=%h wstrb=%h want 020/a5a55a5a/3",
                                       axi_awaddr, axi_wdata, axi_wstrb);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (axi_wvalid !== 1'b0 || host_axi_wready !== 2'b00) begin
                    n_fail++; $display("FAIL wfirst_w_masked: wvalid=%b wready=%b want 0/00", axi_wvalid, host_axi_wready);
                end
            end
            if (axi_awvalid && axi_awready) aw_hs++;
            if (axi_wvalid && axi_wready) w_hs++;
        end
        @(negedge clk);
        host_axi_awvalid = 2'b00; host_axi_wvalid = 2'b00; axi_awready = 1'b0;
        axi_bvalid = 1'b1; axi_bresp = 2'b10; host_axi_bready = 2'b10;
        #1;
        n_cmp++;
        if (aw_hs !== 1 || w_hs !== 1) begin n_fail++; $display("FAIL wfirst_hs_count: aw=%0d w=%0d want 1/1", aw_hs, w_hs); end
        n_cmp++;
        if (host_axi_bvalid !== 2'b10 || host_axi_bresp[3:2] !== 2'b10 || axi_bready !== 1'b1) begin
            n_fail++; $display("FAIL wfirst_resp: bvalid=%b bresp=%b bready=%b want 10/10/1",
                               host_axi_bvalid, host_axi_bresp[3:2], axi_bready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (all_vr() !== 15'h0) begin n_fail++; $display("FAIL wfirst_idle: got %h want 0", all_vr()); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write();
        test_read_stall();
        test_round_robin();
        test_write_priority();
        test_w_before_aw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
